// File: rtl/conv_sched_pkg.sv
// Shared types and derived-size helpers for the convolution lane scheduler.
package conv_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ALLOC = 2'd1,
    ISSUE = 2'd2,
    DONE  = 2'd3
  } schedState_e;

  localparam int DEF_N     = 32;
  localparam int DEF_F     = 3;
  localparam int DEF_K     = 3;
  localparam int DEF_NF    = 3;
  localparam int DEF_P     = 1;
  localparam int DEF_S     = 1;
  localparam int DEF_NMULT = 64;

  function automatic int calcOut(input int n, input int f, input int p, input int s);
    return (n - f + 2 * p) / s + 1;
  endfunction

  function automatic int calcWin(input int f, input int k);
    return f * f * k;
  endfunction

  function automatic int maxOf(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/free_lane_picker.sv
// Counts the free multiplier lanes and selects the lowest cnt_limit of them.
module free_lane_picker #(
  parameter int NMULT = 64,
  parameter int CW    = 7,
  parameter int LW    = 7
) (
  input  logic [NMULT-1:0] free,
  input  logic [LW-1:0]    cnt_limit,
  output logic [NMULT-1:0] mask,
  output logic [CW-1:0]    pc
);

  logic [LW-1:0] taken;

  // Priority scan from lane 0 upward; lanes past the limit are counted but not granted.
  always_comb begin
    mask  = '0;
    pc    = '0;
    taken = '0;
    for (int i = 0; i < NMULT; i++) begin
      if (free[i]) begin
        pc = pc + CW'(1);
        if (taken < cnt_limit) begin
          mask[i] = 1'b1;
          taken   = taken + LW'(1);
        end
      end
    end
  end

endmodule

// File: rtl/conv_lane_scheduler.sv
// Walks every output pixel of every filter and issues each F*F*K window to the
// multiplier array in one (FULL) or several (PARTIAL) lane-mask beats.
module conv_lane_scheduler
  import conv_sched_pkg::*;
#(
  parameter int N     = DEF_N,
  parameter int F     = DEF_F,
  parameter int K     = DEF_K,
  parameter int NF    = DEF_NF,
  parameter int P     = DEF_P,
  parameter int S     = DEF_S,
  parameter int NMULT = DEF_NMULT,
  localparam int OUT  = calcOut(N, F, P, S),
  localparam int WIN  = calcWin(F, K),
  localparam int OW   = $clog2(OUT),
  localparam int FW   = $clog2(NF),
  localparam int EW   = $clog2(WIN + 1),
  localparam int CW   = $clog2(NMULT + 1),
  localparam int GW   = $clog2(N) + 2
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start,
  input  logic             en,
  input  logic [NMULT-1:0] mult_free,
  output logic             job_valid,
  input  logic             job_ready,
  output logic [NMULT-1:0] job_mask,
  output logic [CW-1:0]    job_count,
  output logic [EW-1:0]    job_elem_base,
  output logic [OW-1:0]    job_oy,
  output logic [OW-1:0]    job_ox,
  output logic [FW-1:0]    job_f,
  output logic [GW-1:0]    job_iy0,
  output logic [GW-1:0]    job_ix0,
  output logic             job_last,
  output logic             busy,
  output logic             done,
  output logic             aborted
);

  localparam int LW = maxOf(CW, EW);

  schedState_e      state_q, state_d;
  logic [NMULT-1:0] mask_q, mask_d;
  logic [CW-1:0]    count_q, count_d;
  logic [EW-1:0]    elemBase_q, elemBase_d;
  logic [OW-1:0]    oy_q, oy_d, ox_q, ox_d;
  logic [FW-1:0]    f_q, f_d;
  logic [GW-1:0]    iy0_q, iy0_d, ix0_q, ix0_d;
  logic             last_q, last_d;
  logic             done_q, done_d;
  logic             aborted_q, aborted_d;

  logic [NMULT-1:0] pickMask;
  logic [CW-1:0]    pickPc;
  logic [LW-1:0]    rem, pcExt, cnt;
  logic             lastOx, lastOy, lastF;

  assign rem    = LW'(WIN) - LW'(elemBase_q);
  assign pcExt  = LW'(pickPc);
  assign cnt    = (pcExt >= rem) ? rem : pcExt;
  assign lastOx = (ox_q == OW'(OUT - 1));
  assign lastOy = (oy_q == OW'(OUT - 1));
  assign lastF  = (f_q == FW'(NF - 1));

  free_lane_picker #(
    .NMULT (NMULT),
    .CW    (CW),
    .LW    (LW)
  ) u_picker (
    .free      (mult_free),
    .cnt_limit (rem),
    .mask      (pickMask),
    .pc        (pickPc)
  );

  // Window origin in signed two's complement; negative means it starts in the padding.
  function automatic logic [GW-1:0] originOf(input logic [OW-1:0] o);
    return GW'(o) * GW'(S) - GW'(P);
  endfunction

  always_comb begin
    state_d    = state_q;
    mask_d     = mask_q;
    count_d    = count_q;
    elemBase_d = elemBase_q;
    oy_d       = oy_q;
    ox_d       = ox_q;
    f_d        = f_q;
    iy0_d      = iy0_q;
    ix0_d      = ix0_q;
    last_d     = last_q;
    done_d     = 1'b0;
    aborted_d  = 1'b0;

    if (state_q != IDLE && !en) begin
      state_d   = IDLE;
      aborted_d = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (start && en) begin
            state_d    = ALLOC;
            elemBase_d = '0;
            oy_d       = '0;
            ox_d       = '0;
            f_d        = '0;
          end
        end
        ALLOC: begin
          if (pickPc != '0) begin
            mask_d  = pickMask;
            count_d = CW'(cnt);
            last_d  = (pcExt >= rem);
            iy0_d   = originOf(oy_q);
            ix0_d   = originOf(ox_q);
            state_d = ISSUE;
          end
        end
        ISSUE: begin
          if (job_ready) begin
            state_d = ALLOC;
            if (last_q) begin
              elemBase_d = '0;
              // ox is the fastest index, then oy, then filter.
              if (!lastOx) begin
                ox_d = ox_q + OW'(1);
              end else begin
                ox_d = '0;
                if (!lastOy) begin
                  oy_d = oy_q + OW'(1);
                end else begin
                  oy_d = '0;
                  if (!lastF) begin
                    f_d = f_q + FW'(1);
                  end else begin
                    f_d     = '0;
                    state_d = DONE;
                    done_d  = 1'b1;
                  end
                end
              end
            end else begin
              elemBase_d = elemBase_q + EW'(count_q);
            end
          end
        end
        DONE: state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= IDLE;
      mask_q     <= '0;
      count_q    <= '0;
      elemBase_q <= '0;
      oy_q       <= '0;
      ox_q       <= '0;
      f_q        <= '0;
      iy0_q      <= '0;
      ix0_q      <= '0;
      last_q     <= 1'b0;
      done_q     <= 1'b0;
      aborted_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      mask_q     <= mask_d;
      count_q    <= count_d;
      elemBase_q <= elemBase_d;
      oy_q       <= oy_d;
      ox_q       <= ox_d;
      f_q        <= f_d;
      iy0_q      <= iy0_d;
      ix0_q      <= ix0_d;
      last_q     <= last_d;
      done_q     <= done_d;
      aborted_q  <= aborted_d;
    end
  end

  assign job_valid     = (state_q == ISSUE);
  assign job_mask      = mask_q;
  assign job_count     = count_q;
  assign job_elem_base = elemBase_q;
  assign job_oy        = oy_q;
  assign job_ox        = ox_q;
  assign job_f         = f_q;
  assign job_iy0       = iy0_q;
  assign job_ix0       = ix0_q;
  assign job_last      = last_q;
  assign busy          = (state_q != IDLE);
  assign done          = done_q;
  assign aborted       = aborted_q;

endmodule

// File: tb/tb_conv_lane_scheduler.sv
// Scoreboard bench for conv_lane_scheduler: default build plus a stride-2 build.
`timescale 1ns/1ps
module tb_conv_lane_scheduler;
  import conv_sched_pkg::*;

  localparam int NF  = 3;
  localparam int OUT = 32;
  localparam int WIN = 27;

  typedef struct packed {
    logic [63:0] mask;
    logic [6:0]  count;
    logic [4:0]  base;
    logic [4:0]  oy;
    logic [4:0]  ox;
    logic [1:0]  f;
    logic [6:0]  iy0;
    logic [6:0]  ix0;
    logic        last;
  } beat_t;

  logic        clk, rstn;
  logic        start, en, job_ready;
  logic [63:0] multFree;
  logic        job_valid, job_last, busy, done, aborted;
  logic [63:0] job_mask;
  logic [6:0]  job_count;
  logic [4:0]  job_elem_base, job_oy, job_ox;
  logic [1:0]  job_f;
  logic [6:0]  job_iy0, job_ix0;

  logic        start2, en2, ready2;
  logic [63:0] free2;
  logic        valid2, last2, busy2, done2, aborted2;
  logic [63:0] mask2;
  logic [6:0]  count2;
  logic [4:0]  base2;
  logic [3:0]  oy2, ox2;
  logic [1:0]  f2;
  logic [6:0]  iy02, ix02;

  beat_t        curBeat;
  logic [106:0] allOuts;
  assign curBeat = {job_mask, job_count, job_elem_base, job_oy, job_ox, job_f, job_iy0, job_ix0, job_last};
  assign allOuts = {job_valid, curBeat, busy, done, aborted};

  int    checks = 0;
  int    errors = 0;
  beat_t expQ[$];
  bit    finQ[$];
  int    beatsSeen = 0;
  int    layersDone = 0;
  bit    doneDue = 0;
  bit    abortDue = 0;
  bit    dut2Done = 0;

  conv_lane_scheduler u_dut (
    .clk(clk), .rstn(rstn), .start(start), .en(en), .mult_free(multFree),
    .job_valid(job_valid), .job_ready(job_ready), .job_mask(job_mask), .job_count(job_count),
    .job_elem_base(job_elem_base), .job_oy(job_oy), .job_ox(job_ox), .job_f(job_f),
    .job_iy0(job_iy0), .job_ix0(job_ix0), .job_last(job_last),
    .busy(busy), .done(done), .aborted(aborted)
  );

  conv_lane_scheduler #(.S(2)) u_dut2 (
    .clk(clk), .rstn(rstn), .start(start2), .en(en2), .mult_free(free2),
    .job_valid(valid2), .job_ready(ready2), .job_mask(mask2), .job_count(count2),
    .job_elem_base(base2), .job_oy(oy2), .job_ox(ox2), .job_f(f2),
    .job_iy0(iy02), .job_ix0(ix02), .job_last(last2),
    .busy(busy2), .done(done2), .aborted(aborted2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  // Lowest cnt set bits of the free bitmap.
  function automatic logic [63:0] lowestBits(input logic [63:0] free, input int cnt);
    logic [63:0] m;
    int taken;
    m = '0;
    taken = 0;
    for (int i = 0; i < 64; i++) begin
      if (free[i] && taken < cnt) begin
        m[i] = 1'b1;
        taken++;
      end
    end
    return m;
  endfunction

  // Reference: every window split into beats of min(freeLanes, remaining) elements.
  task automatic pushLayer(input logic [63:0] free);
    int pc, base, cnt;
    beat_t b;
    pc = $countones(free);
    if (pc == 0) return;
    for (int f = 0; f < NF; f++) begin
      for (int oy = 0; oy < OUT; oy++) begin
        for (int ox = 0; ox < OUT; ox++) begin
          base = 0;
          while (base < WIN) begin
            cnt     = (pc < WIN - base) ? pc : WIN - base;
            b.mask  = lowestBits(free, cnt);
            b.count = 7'(cnt);
            b.base  = 5'(base);
            b.oy    = 5'(oy);
            b.ox    = 5'(ox);
            b.f     = 2'(f);
            b.iy0   = 7'(oy - 1);
            b.ix0   = 7'(ox - 1);
            b.last  = (base + cnt == WIN);
            expQ.push_back(b);
            finQ.push_back(f == NF - 1 && oy == OUT - 1 && ox == OUT - 1 && b.last);
            base += cnt;
          end
        end
      end
    end
  endtask

  task automatic applyStimulus();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic waitLayer(input string name, input int budget);
    int l0;
    bit seen;
    l0 = layersDone;
    seen = 0;
    for (int c = 0; c < budget && !seen; c++) begin
      @(negedge clk); #1;
      if (layersDone > l0) seen = 1;
    end
    checkOutput({name, "_done"}, 128'(seen), 128'(1));
    checkOutput({name, "_drained"}, 128'(expQ.size()), 128'(0));
    expQ.delete();
    finQ.delete();
  endtask

  // Called just after a rising edge; the abort takes effect on the next edge.
  task automatic abortLayer(input string name);
    job_ready = 1'b0;
    en = 1'b0;
    abortDue = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checkOutput({name, "_pulse"}, 128'({aborted, busy, job_valid, done}), 128'(4'b1000));
    #1 abortDue = 1'b0;
    @(negedge clk);
    checkOutput({name, "_one_cycle"}, 128'({aborted, busy}), 128'(0));
    expQ.delete();
    finQ.delete();
    en = 1'b1;
    job_ready = 1'b1;
  endtask

  // Monitor: pops the scoreboard on every handshake and polices pulses and payload hold.
  initial begin : monitor
    beat_t exp, prevBeat;
    bit fin, holdPrev;
    holdPrev = 0;
    prevBeat = '0;
    forever begin
      @(negedge clk);
      if (done) layersDone++;
      if (doneDue) begin
        checkOutput("done_after_last", 128'(done), 128'(1));
        doneDue = 0;
      end else if (done) begin
        checkOutput("spurious_done", 128'(done), 128'(0));
      end
      if (aborted && !abortDue) checkOutput("spurious_aborted", 128'(aborted), 128'(0));
      if (rstn && job_valid && holdPrev) checkOutput("payload_stable", 128'(curBeat), 128'(prevBeat));
      holdPrev = rstn && job_valid && !job_ready;
      prevBeat = curBeat;
      if (rstn && job_valid && job_ready) begin
        if (expQ.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_beat: got %0h expected none", curBeat);
        end else begin
          exp = expQ.pop_front();
          fin = finQ.pop_front();
          checkOutput("beat", 128'(curBeat), 128'(exp));
          beatsSeen++;
          if (fin) doneDue = 1;
        end
      end
    end
  end

  // Stride-2 build: every beat is a full window, origins step by 2.
  initial begin : dut2Check
    bit ok;
    int w;
    start2 = 1'b0;
    en2 = 1'b1;
    ready2 = 1'b1;
    free2 = '1;
    ok = 1;
    @(posedge rstn);
    @(posedge clk); #1 start2 = 1'b1;
    @(posedge clk); #1 start2 = 1'b0;
    for (int f = 0; f < NF && ok; f++) begin
      for (int oy = 0; oy < 16 && ok; oy++) begin
        for (int ox = 0; ox < 16 && ok; ox++) begin
          w = 0;
          do begin
            @(negedge clk);
            w++;
          end while (!valid2 && w < 20);
          if (!valid2) begin
            ok = 0;
            checks++;
            errors++;
            $display("[TB] FAIL s2_timeout: got no beat expected beat f=%0d oy=%0d ox=%0d", f, oy, ox);
          end else begin
            checkOutput("s2_beat", 128'({oy2, ox2, f2, iy02, ix02, last2, count2, mask2}),
                        128'({4'(oy), 4'(ox), 2'(f), 7'(2 * oy - 1), 7'(2 * ox - 1), 1'b1, 7'd27, 64'h7FF_FFFF}));
          end
        end
      end
    end
    @(negedge clk);
    checkOutput("s2_done", 128'(done2), 128'(1));
    dut2Done = 1;
  end

  initial begin : mainStim
    logic [63:0] f0;
    int b0, l0, stretch;
    bit forced, rdy;
    rstn = 1'b0;
    start = 1'b0;
    en = 1'b1;
    job_ready = 1'b1;
    multFree = '1;
    #12;
    checkOutput("reset_outputs", 128'(allOuts), 128'(0));
    @(posedge clk); #1 rstn = 1'b1;

    $display("[TB] full-width layer");
    pushLayer('1);
    applyStimulus();
    checkOutput("busy_after_start", 128'({busy, job_valid}), 128'(2'b10));
    waitLayer("full", 10000);

    $display("[TB] 16-lane partial layer");
    multFree = 64'hFFFF;
    pushLayer(64'hFFFF);
    applyStimulus();
    waitLayer("partial", 20000);

    $display("[TB] stall then four lanes");
    multFree = '0;
    pushLayer(64'hF0);
    applyStimulus();
    repeat (10) begin
      @(negedge clk);
      checkOutput("stall", 128'({job_valid, busy}), 128'(2'b01));
    end
    @(posedge clk); #1 multFree = 64'hF0;
    b0 = beatsSeen;
    for (int c = 0; c < 200 && beatsSeen < b0 + 10; c++) begin
      @(posedge clk); #1;
    end
    checkOutput("four_lane_beats", 128'(beatsSeen >= b0 + 10), 128'(1));
    abortLayer("abort_stall");

    $display("[TB] backpressure with toggling free map");
    f0 = {$urandom, $urandom};
    if (f0 == '0) f0 = 64'h1;
    multFree = f0;
    pushLayer(f0);
    applyStimulus();
    l0 = layersDone;
    forced = 0;
    stretch = 0;
    for (int c = 0; c < 60000 && layersDone == l0; c++) begin
      @(posedge clk); #1;
      if (!forced && beatsSeen >= 100 && job_valid) begin
        forced = 1;
        stretch = 5;
      end
      if (stretch > 0) begin
        rdy = 1'b0;
        stretch--;
      end else begin
        rdy = ($urandom_range(0, 3) != 0);
      end
      job_ready = rdy;
      multFree = (job_valid && !rdy) ? {$urandom, $urandom} : f0;
    end
    job_ready = 1'b1;
    multFree = '1;
    checkOutput("bp_layer_done", 128'(layersDone > l0), 128'(1));
    checkOutput("bp_drained", 128'(expQ.size()), 128'(0));
    expQ.delete();
    finQ.delete();

    $display("[TB] abort at pixel (3,7)");
    pushLayer('1);
    applyStimulus();
    forced = 0;
    for (int c = 0; c < 2000 && !forced; c++) begin
      @(posedge clk); #1;
      if (job_valid && job_oy == 5'd3 && job_ox == 5'd7 && job_f == 2'd0) forced = 1;
    end
    checkOutput("abort_pixel_payload", 128'(curBeat), 128'(expQ.size() > 0 ? expQ[0] : '0));
    abortLayer("abort_issue");
    pushLayer('1);
    applyStimulus();
    waitLayer("restart", 10000);

    for (int c = 0; c < 5000 && !dut2Done; c++) @(negedge clk);
    checkOutput("s2_finished", 128'(dut2Done), 128'(1));

    $display("[TB] asynchronous reset mid-layer");
    pushLayer('1);
    applyStimulus();
    b0 = beatsSeen;
    for (int c = 0; c < 500 && beatsSeen < b0 + 20; c++) begin
      @(posedge clk); #1;
    end
    @(posedge clk); #3 rstn = 1'b0;
    #1 checkOutput("async_reset", 128'(allOuts), 128'(0));
    expQ.delete();
    finQ.delete();
    @(posedge clk); #1 rstn = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("post_reset_idle", 128'({busy, done, aborted, job_valid}), 128'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
